multicycle_ctrl: RTL and testbench



---
 rtl/friscv_pkg.sv | 21 ++
 rtl/ctrl_out_decode.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 82 ++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/friscv_pkg.sv
// friscv_pkg: shared FRiscV constants, opcode values and control enums.
package friscv_pkg;
   localparam int ARCH = 32;
   localparam logic [6:0] REG       = 7'b0110011;
   localparam logic [6:0] IMM_ARITH = 7'b0010011;
   localparam logic [6:0] IMM_LOAD  = 7'b0000011;
   localparam logic [6:0] STORE     = 7'b0100011;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] JUMP      = 7'b1101111;
   localparam logic [6:0] IMM_JUMP  = 7'b1100111;
   localparam logic [6:0] U_L_LOAD  = 7'b0110111;
   typedef enum logic [3:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} ctrl_state_t;
   typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JUMP} pc_sel_t;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
   function automatic logic is_legal(input logic [6:0] op);
      return op inside {REG, IMM_ARITH, IMM_LOAD, STORE, BRANCH, JUMP, IMM_JUMP, U_L_LOAD};
   endfunction
   function automatic logic uses_imm(input logic [6:0] op);
      return op inside {IMM_ARITH, IMM_LOAD, STORE, IMM_JUMP, U_L_LOAD};
   endfunction
endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: combinational state+opcode -> datapath enables and selects.
// Enables are 0 outside the state that owns them; selects default to 0 when unused.
module ctrl_out_decode
   import friscv_pkg::*;
(
   input  ctrl_state_t i_state,
   input  logic [6:0]  i_op,
   input  logic        i_imem_ack,
   input  logic        i_dmem_ack,
   input  logic        i_branch_taken,
   output logic        o_imem_req,
   output logic        o_instr_we,
   output logic        o_pc_we,
   output logic [1:0]  o_pc_sel,
   output logic        o_alu_src,
   output logic        o_rf_we,
   output logic [1:0]  o_wb_sel,
   output logic        o_dmem_req,
   output logic        o_dmem_we
);
   logic w_ex, w_mem, w_wb, w_br, w_st, w_jmp;
   always_comb begin
      w_ex       = i_state == EXECUTE;
      w_mem      = i_state == MEM;
      w_wb       = i_state == WRITEBACK;
      w_br       = w_ex && i_op == BRANCH;
      w_st       = i_op == STORE;
      w_jmp      = i_op == JUMP || i_op == IMM_JUMP;
      o_imem_req = i_state == FETCH;
      o_instr_we = i_state == FETCH && i_imem_ack;
      o_alu_src  = w_ex && uses_imm(i_op);
      o_dmem_req = w_mem;
      o_dmem_we  = w_mem && w_st;
      // unknown opcodes reach WRITEBACK only as NOPs, so they never write the register file
      o_rf_we    = w_wb && is_legal(i_op);
      o_wb_sel   = !w_wb ? WB_ALU : i_op == IMM_LOAD ? WB_MEM : w_jmp ? WB_PC4 : WB_ALU;
      o_pc_we    = w_wb || w_br || (w_mem && w_st && i_dmem_ack);
      o_pc_sel   = (w_wb && w_jmp) ? PC_JUMP : (w_br && i_branch_taken) ? PC_BRANCH : PC_PLUS4;
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FRiscV multi-cycle control FSM with retire counter and fault flag.
// Define FRISCV_ILLEGAL_TRAP_EN to halt on unknown opcodes instead of retiring them as NOPs.
module multicycle_ctrl #(
   parameter int ARCH         = friscv_pkg::ARCH,
   parameter int IMEM_TIMEOUT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [6:0]      op_code_in,
   input  logic            imem_ack_in,
   input  logic            dmem_ack_in,
   input  logic            branch_taken_in,
   output logic            imem_req_out,
   output logic            instr_we_out,
   output logic            pc_we_out,
   output logic [1:0]      pc_sel_out,
   output logic            alu_src_out,
   output logic            rf_we_out,
   output logic [1:0]      wb_sel_out,
   output logic            dmem_req_out,
   output logic            dmem_we_out,
   output logic [3:0]      state_out,
   output logic            fault_out,
   output logic [ARCH-1:0] instret_out
);
   import friscv_pkg::*;
   ctrl_state_t     r_state;
   logic [6:0]      r_op;
   logic            r_fault;
   logic [ARCH-1:0] r_instret;
   logic [31:0]     r_tmo;
   logic            w_pc_we, w_tmo;
   ctrl_out_decode u_dec (
      .i_state(r_state), .i_op(r_op), .i_imem_ack(imem_ack_in), .i_dmem_ack(dmem_ack_in),
      .i_branch_taken(branch_taken_in), .o_imem_req(imem_req_out), .o_instr_we(instr_we_out),
      .o_pc_we(w_pc_we), .o_pc_sel(pc_sel_out), .o_alu_src(alu_src_out), .o_rf_we(rf_we_out),
      .o_wb_sel(wb_sel_out), .o_dmem_req(dmem_req_out), .o_dmem_we(dmem_we_out)
   );
   // r_tmo holds the number of ack-less FETCH cycles already elapsed
   assign w_tmo = IMEM_TIMEOUT > 0 && r_tmo == 32'(IMEM_TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FETCH;
         r_op      <= '0;
         r_fault   <= 1'b0;
         r_instret <= '0;
         r_tmo     <= '0;
      end else begin
         if (w_pc_we) r_instret <= r_instret + 1'b1;
         r_tmo <= (r_state == FETCH && !imem_ack_in) ? r_tmo + 1'b1 : '0;
         case (r_state)
            FETCH: begin
               if (imem_ack_in) r_state <= DECODE;
               else if (w_tmo) begin
                  r_fault <= 1'b1;
                  r_state <= HALT;
               end
            end
            DECODE: begin
               r_op <= op_code_in;
               if (is_legal(op_code_in)) r_state <= EXECUTE;
               else begin
`ifdef FRISCV_ILLEGAL_TRAP_EN
                  r_fault <= 1'b1;
                  r_state <= HALT;
`else
                  r_state <= WRITEBACK;
`endif
               end
            end
            EXECUTE:   r_state <= r_op == BRANCH ? FETCH : (r_op == IMM_LOAD || r_op == STORE) ? MEM : WRITEBACK;
            MEM:       if (dmem_ack_in) r_state <= r_op == STORE ? FETCH : WRITEBACK;
            WRITEBACK: r_state <= FETCH;
            default:   r_state <= HALT;
         endcase
      end
   end
   assign pc_we_out   = w_pc_we;
   assign state_out   = r_state;
   assign fault_out   = r_fault;
   assign instret_out = r_instret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction streams expanded into expected per-cycle control vectors.
module tb_multicycle_ctrl;
   import friscv_pkg::*;
   localparam int TMO = 8;
   logic            clk = 1'b0, rst = 1'b1;
   logic [6:0]      op_code_in;
   logic            imem_ack_in, dmem_ack_in, branch_taken_in;
   logic            imem_req_out, instr_we_out, pc_we_out, alu_src_out, rf_we_out;
   logic            dmem_req_out, dmem_we_out, fault_out;
   logic [1:0]      pc_sel_out, wb_sel_out;
   logic [3:0]      state_out;
   logic [ARCH-1:0] instret_out;

   multicycle_ctrl #(.ARCH(ARCH), .IMEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .op_code_in(op_code_in), .imem_ack_in(imem_ack_in),
      .dmem_ack_in(dmem_ack_in), .branch_taken_in(branch_taken_in), .imem_req_out(imem_req_out),
      .instr_we_out(instr_we_out), .pc_we_out(pc_we_out), .pc_sel_out(pc_sel_out),
      .alu_src_out(alu_src_out), .rf_we_out(rf_we_out), .wb_sel_out(wb_sel_out),
      .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .state_out(state_out),
      .fault_out(fault_out), .instret_out(instret_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic imem_req, instr_we, pc_we;
      logic [1:0] pc_sel;
      logic alu_src, rf_we;
      logic [1:0] wb_sel;
      logic dmem_req, dmem_we, fault;
      logic [ARCH-1:0] instret;
   } exp_t;

   exp_t            q[$];
   int              n_vec = 0, n_err = 0;
   logic [ARCH-1:0] m_instret;
   logic            m_fault;
   logic [6:0]      ops[8] = '{REG, IMM_ARITH, IMM_LOAD, STORE, BRANCH, JUMP, IMM_JUMP, U_L_LOAD};

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e, a;
         e = q.pop_front();
         a = {state_out, imem_req_out, instr_we_out, pc_we_out, pc_sel_out, alu_src_out, rf_we_out,
              wb_sel_out, dmem_req_out, dmem_we_out, fault_out, instret_out};
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL vec %0d: state got %0d want %0d, outputs got %h want %h", n_vec, a.st, e.st, a, e);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   function automatic bit legal(input logic [6:0] op);
      foreach (ops[i]) if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t mk(input logic [3:0] st, input logic ir, iw, pw, input logic [1:0] ps,
                               input logic as, rw, input logic [1:0] ws, input logic dr, dw);
      return {st, ir, iw, pw, ps, as, rw, ws, dr, dw, m_fault, m_instret};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic noise();
      op_code_in      = 7'($urandom);
      imem_ack_in     = 1'($urandom);
      dmem_ack_in     = 1'($urandom);
      branch_taken_in = 1'($urandom);
   endtask

   task automatic step(input exp_t e);
      q.push_back(e);
      if (e.pc_we) m_instret = m_instret + 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      noise();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_fault = 1'b0;
      m_instret = '0;
   endtask

   task automatic halt();
      repeat (20) begin
         noise();
         step(mk(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
   endtask

   // di = ack-less FETCH cycles before the ack, dd = ack-less MEM cycles before the ack
   task automatic run_instr(input logic [6:0] op, input int di, input int dd, input logic bt,
                            input bit abort, output int cyc, output bit hlt);
      bit imm, br, st, jmp;
      cyc = 0;
      hlt = 0;
      for (int k = 0; k < di && k < TMO; k++) begin
         noise(); imem_ack_in = 0;
         step(mk(FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0)); cyc++;
      end
      if (di >= TMO) begin
         m_fault = 1'b1; halt(); hlt = 1; return;
      end
      noise(); imem_ack_in = 1;
      step(mk(FETCH, 1, 1, 0, 0, 0, 0, 0, 0, 0)); cyc++;
      noise(); op_code_in = op;
      step(mk(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0)); cyc++;
      if (!legal(op)) begin
`ifdef FRISCV_ILLEGAL_TRAP_EN
         m_fault = 1'b1; halt(); hlt = 1; return;
`else
         noise();
         step(mk(WRITEBACK, 0, 0, 1, 0, 0, 0, 0, 0, 0)); cyc++;
         return;
`endif
      end
      imm = op inside {IMM_ARITH, IMM_LOAD, STORE, IMM_JUMP, U_L_LOAD};
      br  = op == BRANCH;
      st  = op == STORE;
      jmp = op == JUMP || op == IMM_JUMP;
      noise(); branch_taken_in = bt;
      step(mk(EXECUTE, 0, 0, br, (br && bt) ? 2'd1 : 2'd0, imm, 0, 0, 0, 0)); cyc++;
      if (br) return;
      if (op == IMM_LOAD || st) begin
         for (int k = 0; k < dd; k++) begin
            noise(); dmem_ack_in = 0;
            step(mk(MEM, 0, 0, 0, 0, 0, 0, 0, 1, st)); cyc++;
            if (abort) begin do_reset(); return; end
         end
         noise(); dmem_ack_in = 1;
         step(mk(MEM, 0, 0, st, 0, 0, 0, 0, 1, st)); cyc++;
         if (st) return;
      end
      noise();
      step(mk(WRITEBACK, 0, 0, 1, jmp ? 2'd2 : 2'd0, 0, 1, op == IMM_LOAD ? 2'd1 : jmp ? 2'd2 : 2'd0, 0, 0)); cyc++;
   endtask

   initial begin
      int c;
      bit h;
      logic [6:0] op;
      noise();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_fault = 1'b0;
      m_instret = '0;
      chk("reset_state", state_out, FETCH);
      chk("reset_imem_req", imem_req_out, 1);
      chk("reset_instret", instret_out, 0);
      run_instr(IMM_ARITH, 0, 0, 0, 0, c, h); chk("addi_cycles", c, 4); chk("addi_instret", instret_out, 1);
      run_instr(IMM_LOAD, 0, 3, 0, 0, c, h);  chk("lw_cycles", c, 8);   chk("lw_instret", instret_out, 2);
      run_instr(STORE, 0, 0, 0, 0, c, h);     chk("sw_cycles", c, 4);   chk("sw_instret", instret_out, 3);
      run_instr(BRANCH, 0, 0, 1, 0, c, h);    chk("beq_t_cycles", c, 3);
      run_instr(BRANCH, 0, 0, 0, 0, c, h);    chk("beq_nt_cycles", c, 3);
      run_instr(IMM_LOAD, 0, 0, 0, 0, c, h);  chk("lw0_cycles", c, 5);
      run_instr(JUMP, 0, 0, 0, 0, c, h);      chk("jal_cycles", c, 4);
      run_instr(IMM_JUMP, 1, 0, 0, 0, c, h);  chk("jalr_cycles", c, 5);
      run_instr(U_L_LOAD, 0, 0, 0, 0, c, h);  chk("lui_cycles", c, 4);  chk("seq_instret", instret_out, 9);
      run_instr(7'h7F, 0, 0, 0, 0, c, h);
`ifdef FRISCV_ILLEGAL_TRAP_EN
      chk("trap_fault", fault_out, 1); chk("trap_instret", instret_out, 9); chk("trap_state", state_out, HALT);
      do_reset();
`else
      chk("nop_cycles", c, 3); chk("nop_instret", instret_out, 10); chk("nop_fault", fault_out, 0);
`endif
      run_instr(REG, TMO - 1, 0, 0, 0, c, h); chk("late_ack_cycles", c, TMO + 3); chk("late_ack_fault", fault_out, 0);
      run_instr(REG, TMO, 0, 0, 0, c, h);     chk("tmo_fault", fault_out, 1);   chk("tmo_state", state_out, HALT);
      do_reset();
      run_instr(IMM_LOAD, 0, 3, 0, 1, c, h);
      chk("rst_mid_mem_state", state_out, FETCH); chk("rst_mid_mem_dmem_req", dmem_req_out, 0);
      force dut.r_instret = '1;
      m_instret = '1;
      #1 release dut.r_instret;
      run_instr(IMM_ARITH, 0, 0, 0, 0, c, h); chk("instret_wrap", instret_out, 0);
      repeat (300) begin
         int r;
         int di, dd;
         r = $urandom_range(0, 9);
         if (r < 8) op = ops[r];
         else begin
            op = 7'($urandom);
            while (legal(op)) op = 7'($urandom);
         end
         di = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 2);
         dd = $urandom_range(0, 3);
         run_instr(op, di, dd, 1'($urandom), dd > 0 && $urandom_range(0, 15) == 0, c, h);
         if (h) do_reset();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
